apb_scaled_delayer: RTL and testbench
=====================================

# apb_scaled_delayer

Parametrised APB delayer placed between the CPU-side APB bridge and slow APB peripherals. It forwards one transfer at a time to the downstream slave and measures the slave's access latency in cycles. It then holds the upstream response until that latency, multiplied by a fixed-point ratio `RATIO`, has elapsed, so device timing can be emulated at a different core/peripheral clock ratio. The response data is registered, and the downstream bus is released as soon as the slave completes, so a transfer is never repeated.

## Interface
Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; `pstrb` is `DATA_W/8` bits.
- `FRAC_W`, default 8: fractional bits of `RATIO`.
- `RATIO`, default 256 (1.0): delay scale factor, unsigned fixed point with `FRAC_W` fractional bits, 16-bit field.
- `CNT_W`, default 16: width of the latency and remaining-cycle counters; both saturate.

Ports:
- `clock`, in, 1: single clock; all state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset (0 = reset).
- `in_paddr` in ADDR_W, `in_psel` in 1, `in_penable` in 1, `in_pprot` in 3, `in_pwrite` in 1, `in_pwdata` in DATA_W, `in_pstrb` in DATA_W/8: upstream APB request.
- `in_pready` out 1, `in_prdata` out DATA_W, `in_pslverr` out 1: upstream response, all registered.
- `out_paddr` out ADDR_W, `out_psel` out 1, `out_penable` out 1, `out_pprot` out 3, `out_pwrite` out 1, `out_pwdata` out DATA_W, `out_pstrb` out DATA_W/8: downstream request, all registered.
- `out_pready` in 1, `out_prdata` in DATA_W, `out_pslverr` in 1: downstream response.

## Operation
- FSM states and transitions:
  - IDLE → REQ when `in_psel`=1. Latch paddr, pprot, pwrite, pwdata and pstrb. Clear the latency counter k.
  - REQ: `out_psel`=1, `out_penable`=0. Always moves to ACC.
  - ACC: `out_psel`=1, `out_penable`=1; k increments each cycle, saturating at 2^CNT_W−1.
    - On `out_pready`=1, the final k includes that cycle, so k ≥ 1. Capture `out_prdata` and `out_pslverr`.
    - Compute T = (k·RATIO + 2^(FRAC_W−1)) >> FRAC_W. The product is CNT_W+16 bits; T saturates at 2^CNT_W−1.
    - Load rem = T−k if T>k, else 0. Go to WAIT if rem>0, else to RESP.
  - WAIT: `out_psel`=`out_penable`=0. rem decrements each cycle; at rem=1 go to RESP.
  - RESP: `in_pready`=1 for exactly one cycle, with `in_prdata` and `in_pslverr` holding the captured values. Return to IDLE.
- `in_pready`=0 in every state except RESP.
- `in_prdata` and `in_pslverr` hold the last captured values between transfers.
- `out_p*` address, data and control registers hold their last values while `out_psel`=0.
- A write transfer returns `in_prdata` equal to whatever `out_prdata` was at completion; `in_pslverr` is propagated unchanged.
- Upstream protocol violations are not checked: `in_psel` dropping mid-transfer and request fields changing after latch are ignored.
- With RATIO=256, T=k, so there is no WAIT state; the only added latency is the REQ and RESP stages.

## Timing
- Reset values: FSM in IDLE. `in_pready`, `in_pslverr`, `out_psel`, `out_penable` and `out_pwrite` are 0; all data, address, prot and strb outputs are 0; k=rem=0.
- If reset is asserted mid-transfer, the block returns to IDLE immediately and asynchronously. The downstream transfer is abandoned, and no response is given upstream.
- Cycle numbering, with cycle 0 = upstream setup sampled in IDLE:
  - REQ in cycle 1.
  - ACC in cycles 2..k+1.
  - WAIT for max(T−k, 0) cycles.
  - `in_pready` high in cycle max(T,k)+2.
- The earliest next upstream setup is sampled in the cycle after RESP. There are no back-to-back overlaps.
- A ratio below 1.0 cannot shorten latency below the measured k.

## Structure
- Package `apb_delayer_pkg`: FSM state enum (IDLE, REQ, ACC, WAIT, RESP), default ratio constant, and the `scale_latency` rounding/saturation function.
- Sub-module `apb_delay_calc`: computes rem from k, RATIO and FRAC_W. Purely combinational, reused by the AXI delayer.

## Test plan
- RATIO=256, slave ready on 1st ACC cycle, read returning 0xDEADBEEF → `in_pready` at cycle 3, `in_prdata`=0xDEADBEEF, and exactly one `out_psel` burst.
- RATIO=768 (3.0), slave ready after 2 ACC cycles, write 0x12345678 to 0x1000_0004 with pstrb 0xF → downstream sees identical fields, WAIT lasts 4 cycles, `in_pready` at cycle 8.
- RATIO=320 (1.25), k=3 → T=(960+128)>>8=4, WAIT 1 cycle; RATIO=128 (0.5), k=4 → no WAIT, `in_pready` at cycle 6.
- Slave returns `out_pslverr`=1 → `in_pslverr`=1 for the single RESP cycle, then held; the next transfer with pslverr=0 clears it.
- CNT_W=4, RATIO=1024, k=5 → T saturates to 15, rem=10, and the counter never wraps.
- Reset driven low during WAIT → all outputs at reset values asynchronously; the next transfer after reset release completes normally with fresh k.

Source files
------------

// File: rtl/apb_delayer_pkg.sv
// Shared types and latency-scaling helper for the APB/AXI delayers.
package apb_delayer_pkg;

  typedef enum logic [2:0] {StIdle, StReq, StAcc, StWait, StResp} state_e;

  localparam int unsigned DefaultRatio = 256;

  // T = round(k * ratio / 2^frac_w), saturated to cnt_w bits (cnt_w <= 32).
  function automatic logic [31:0] scale_latency(input logic [31:0] k,
                                                input logic [15:0] ratio,
                                                input int unsigned frac_w,
                                                input int unsigned cnt_w);
    logic [63:0] prod;
    logic [63:0] t;
    logic [63:0] limit;
    prod = 64'(k) * 64'(ratio);
    if (frac_w > 0) prod = prod + (64'd1 << (frac_w - 1));
    t     = prod >> frac_w;
    limit = (64'd1 << cnt_w) - 64'd1;
    return (t > limit) ? limit[31:0] : t[31:0];
  endfunction

endpackage

// File: rtl/apb_delay_calc.sv
// Remaining wait cycles after a measured latency k: max(scaled(k) - k, 0).
module apb_delay_calc
  import apb_delayer_pkg::*;
#(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned FRAC_W = 8,
  parameter int unsigned RATIO  = DefaultRatio
) (
  input  logic [CNT_W-1:0] k,
  output logic [CNT_W-1:0] rem
);

  logic [31:0] k_ext;
  logic [31:0] t;

  always_comb begin
    k_ext = 32'(k);
    t     = scale_latency(k_ext, 16'(RATIO), FRAC_W, CNT_W);
    rem   = (t > k_ext) ? CNT_W'(t - k_ext) : '0;
  end

endmodule

// File: rtl/apb_scaled_delayer.sv
// Single-outstanding APB forwarder that stretches the upstream response to
// RATIO times the measured downstream latency.
module apb_scaled_delayer
  import apb_delayer_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned FRAC_W = 8,
  parameter int unsigned RATIO  = DefaultRatio,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   in_paddr,
  input  logic                in_psel,
  input  logic                in_penable,
  input  logic [2:0]          in_pprot,
  input  logic                in_pwrite,
  input  logic [DATA_W-1:0]   in_pwdata,
  input  logic [DATA_W/8-1:0] in_pstrb,
  output logic                in_pready,
  output logic [DATA_W-1:0]   in_prdata,
  output logic                in_pslverr,
  output logic [ADDR_W-1:0]   out_paddr,
  output logic                out_psel,
  output logic                out_penable,
  output logic [2:0]          out_pprot,
  output logic                out_pwrite,
  output logic [DATA_W-1:0]   out_pwdata,
  output logic [DATA_W/8-1:0] out_pstrb,
  input  logic                out_pready,
  input  logic [DATA_W-1:0]   out_prdata,
  input  logic                out_pslverr
);

  state_e           state;
  logic [CNT_W-1:0] k;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] k_inc;
  logic [CNT_W-1:0] rem_calc;

  // Latency including the current ACC cycle, saturating.
  assign k_inc = (k == '1) ? k : k + CNT_W'(1);

  apb_delay_calc #(
    .CNT_W  (CNT_W),
    .FRAC_W (FRAC_W),
    .RATIO  (RATIO)
  ) u_calc (
    .k   (k_inc),
    .rem (rem_calc)
  );

  logic unused_penable;
  assign unused_penable = in_penable;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= StIdle;
      k           <= '0;
      rem         <= '0;
      in_pready   <= 1'b0;
      in_prdata   <= '0;
      in_pslverr  <= 1'b0;
      out_paddr   <= '0;
      out_psel    <= 1'b0;
      out_penable <= 1'b0;
      out_pprot   <= '0;
      out_pwrite  <= 1'b0;
      out_pwdata  <= '0;
      out_pstrb   <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (in_psel) begin
            out_paddr   <= in_paddr;
            out_pprot   <= in_pprot;
            out_pwrite  <= in_pwrite;
            out_pwdata  <= in_pwdata;
            out_pstrb   <= in_pstrb;
            out_psel    <= 1'b1;
            out_penable <= 1'b0;
            k           <= '0;
            state       <= StReq;
          end
        end
        StReq: begin
          out_penable <= 1'b1;
          state       <= StAcc;
        end
        StAcc: begin
          k <= k_inc;
          if (out_pready) begin
            // Release the slave immediately; the response waits upstream.
            in_prdata   <= out_prdata;
            in_pslverr  <= out_pslverr;
            out_psel    <= 1'b0;
            out_penable <= 1'b0;
            rem         <= rem_calc;
            if (rem_calc != '0) begin
              state <= StWait;
            end else begin
              in_pready <= 1'b1;
              state     <= StResp;
            end
          end
        end
        StWait: begin
          rem <= rem - CNT_W'(1);
          if (rem <= CNT_W'(1)) begin
            in_pready <= 1'b1;
            state     <= StResp;
          end
        end
        StResp: begin
          in_pready <= 1'b0;
          state     <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_scaled_delayer.sv
// Bench: five delayer instances with different ratios/counter widths, each
// driven by a behavioural slave with programmable latency.
module tb_apb_scaled_delayer;

  localparam int N = 5;
  localparam int unsigned RATIOS [N] = '{256, 768, 320, 128, 1024};
  localparam int unsigned CNTWS  [N] = '{16, 16, 16, 16, 4};

  logic        clock = 1'b0;
  logic        reset = 1'b0;

  logic [31:0] in_paddr    [N];
  logic        in_psel     [N];
  logic        in_penable  [N];
  logic [2:0]  in_pprot    [N];
  logic        in_pwrite   [N];
  logic [31:0] in_pwdata   [N];
  logic [3:0]  in_pstrb    [N];
  logic        in_pready   [N];
  logic [31:0] in_prdata   [N];
  logic        in_pslverr  [N];
  logic [31:0] out_paddr   [N];
  logic        out_psel    [N];
  logic        out_penable [N];
  logic [2:0]  out_pprot   [N];
  logic        out_pwrite  [N];
  logic [31:0] out_pwdata  [N];
  logic [3:0]  out_pstrb   [N];
  logic        out_pready  [N];
  logic [31:0] out_prdata  [N];
  logic        out_pslverr [N];

  // Slave model state
  int          lat        [N];
  logic [31:0] s_rdata    [N];
  logic        s_err      [N];
  int          acc_cnt    [N];
  int          bursts     [N];
  logic [31:0] seen_addr  [N];
  logic [31:0] seen_wdata [N];
  logic [3:0]  seen_strb  [N];
  logic        seen_write [N];
  logic [2:0]  seen_prot  [N];

  int checks = 0;
  int fails  = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < N; g++) begin : g_dut
    apb_scaled_delayer #(
      .ADDR_W (32),
      .DATA_W (32),
      .FRAC_W (8),
      .RATIO  (RATIOS[g]),
      .CNT_W  (CNTWS[g])
    ) u_dut (
      .clock       (clock),
      .reset       (reset),
      .in_paddr    (in_paddr[g]),
      .in_psel     (in_psel[g]),
      .in_penable  (in_penable[g]),
      .in_pprot    (in_pprot[g]),
      .in_pwrite   (in_pwrite[g]),
      .in_pwdata   (in_pwdata[g]),
      .in_pstrb    (in_pstrb[g]),
      .in_pready   (in_pready[g]),
      .in_prdata   (in_prdata[g]),
      .in_pslverr  (in_pslverr[g]),
      .out_paddr   (out_paddr[g]),
      .out_psel    (out_psel[g]),
      .out_penable (out_penable[g]),
      .out_pprot   (out_pprot[g]),
      .out_pwrite  (out_pwrite[g]),
      .out_pwdata  (out_pwdata[g]),
      .out_pstrb   (out_pstrb[g]),
      .out_pready  (out_pready[g]),
      .out_prdata  (out_prdata[g]),
      .out_pslverr (out_pslverr[g])
    );
  end

  // Slave answers in the lat-th access cycle; bus data is junk otherwise.
  always @(negedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (out_psel[i] && !out_penable[i]) begin
        bursts[i]++;
        seen_addr[i]  = out_paddr[i];
        seen_wdata[i] = out_pwdata[i];
        seen_strb[i]  = out_pstrb[i];
        seen_write[i] = out_pwrite[i];
        seen_prot[i]  = out_pprot[i];
      end
      if (out_psel[i] && out_penable[i]) acc_cnt[i]++;
      else acc_cnt[i] = 0;
      out_pready[i]  = out_psel[i] && out_penable[i] && (acc_cnt[i] == lat[i]);
      out_prdata[i]  = out_pready[i] ? s_rdata[i] : 32'hA5A5_5A5A;
      out_pslverr[i] = out_pready[i] ? s_err[i] : 1'b1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Upstream response cycle from the timing rules: ACC lasts l cycles, then
  // wait round(k*ratio) - k more, with k and T clipped to the counter width.
  function automatic int exp_cycle(input int g, input int l);
    longint kmax;
    longint ks;
    longint t;
    kmax = (64'd1 << CNTWS[g]) - 1;
    ks   = (l > kmax) ? kmax : l;
    t    = (ks * RATIOS[g] + 128) / 256;
    if (t > kmax) t = kmax;
    return l + 2 + ((t > ks) ? int'(t - ks) : 0);
  endfunction

  task automatic xfer(input int g, input logic [31:0] addr, input logic wr,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      input logic [2:0] prot, input int l,
                      input logic [31:0] rdata, input logic err);
    int cyc;
    int got;
    int b0;
    lat[g]     = l;
    s_rdata[g] = rdata;
    s_err[g]   = err;
    b0         = bursts[g];
    @(negedge clock);
    in_paddr[g]   = addr;
    in_pwrite[g]  = wr;
    in_pwdata[g]  = wdata;
    in_pstrb[g]   = strb;
    in_pprot[g]   = prot;
    in_psel[g]    = 1'b1;
    in_penable[g] = 1'b0;
    @(posedge clock);
    cyc = 0;
    got = -1;
    while (got < 0 && cyc < 300) begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) in_penable[g] = 1'b1;
      if (in_pready[g]) got = cyc;
    end
    check("pready_cycle", 64'(got), 64'(exp_cycle(g, l)));
    check("resp_prdata", 64'(in_prdata[g]), 64'(rdata));
    check("resp_pslverr", 64'(in_pslverr[g]), 64'(err));
    in_psel[g]    = 1'b0;
    in_penable[g] = 1'b0;
    @(negedge clock);
    check("pready_one_cycle", 64'(in_pready[g]), 64'd0);
    check("held_resp", {31'd0, in_pslverr[g], in_prdata[g]}, {31'd0, err, rdata});
    check("burst_count", 64'(bursts[g] - b0), 64'd1);
    check("dn_addr_data", {seen_addr[g], seen_wdata[g]}, {addr, wdata});
    check("dn_ctrl", 64'({seen_write[g], seen_strb[g], seen_prot[g]}),
          64'({wr, strb, prot}));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      in_paddr[i] = '0; in_psel[i] = 1'b0; in_penable[i] = 1'b0; in_pprot[i] = '0;
      in_pwrite[i] = 1'b0; in_pwdata[i] = '0; in_pstrb[i] = '0;
      lat[i] = 1; s_rdata[i] = '0; s_err[i] = 1'b0; acc_cnt[i] = 0; bursts[i] = 0;
    end
    repeat (3) @(negedge clock);
    for (int i = 0; i < N; i++) begin
      check("rst_ctrl", 64'({in_pready[i], in_pslverr[i], out_psel[i], out_penable[i],
                              out_pwrite[i], out_pstrb[i], out_pprot[i]}), 64'd0);
      check("rst_data", {in_prdata[i], out_pwdata[i]}, 64'd0);
    end
    reset = 1'b1;
    @(negedge clock);

    // Directed cases
    xfer(0, 32'h4000_0000, 1'b0, 32'h0, 4'h0, 3'h0, 1, 32'hDEAD_BEEF, 1'b0);
    xfer(1, 32'h1000_0004, 1'b1, 32'h1234_5678, 4'hF, 3'h2, 2, 32'h5555_0001, 1'b0);
    xfer(2, 32'h2000_0010, 1'b0, 32'h0, 4'h0, 3'h1, 3, 32'h0BAD_F00D, 1'b0);
    xfer(3, 32'h3000_0020, 1'b1, 32'hFFFF_0000, 4'h3, 3'h4, 4, 32'h7777_8888, 1'b0);
    xfer(0, 32'h4000_0008, 1'b0, 32'h0, 4'h0, 3'h0, 2, 32'h1111_2222, 1'b1);
    repeat (3) @(negedge clock);
    check("pslverr_held", 64'(in_pslverr[0]), 64'd1);
    xfer(0, 32'h4000_000C, 1'b0, 32'h0, 4'h0, 3'h0, 1, 32'h3333_4444, 1'b0);
    xfer(4, 32'h5000_0000, 1'b0, 32'h0, 4'h0, 3'h0, 5, 32'h0000_0005, 1'b0);
    xfer(4, 32'h5000_0004, 1'b0, 32'h0, 4'h0, 3'h0, 20, 32'h0000_0014, 1'b0);

    // Reset during WAIT (RATIO 3.0, k=2: WAIT spans cycles 4..7)
    xfer(1, 32'h1000_0000, 1'b0, 32'h0, 4'h0, 3'h0, 1, 32'hCAFE_F00D, 1'b0);
    lat[1] = 2;
    s_rdata[1] = 32'h9999_9999;
    @(negedge clock);
    in_paddr[1] = 32'h1000_0100; in_pwrite[1] = 1'b1; in_pwdata[1] = 32'hABCD_0123;
    in_pstrb[1] = 4'hC; in_pprot[1] = 3'h7; in_psel[1] = 1'b1; in_penable[1] = 1'b0;
    @(posedge clock);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock);
      if (c == 1) in_penable[1] = 1'b1;
    end
    #2 reset = 1'b0;
    #1;
    check("async_rst_ctrl", 64'({in_pready[1], in_pslverr[1], out_psel[1], out_penable[1],
                                  out_pwrite[1], out_pstrb[1], out_pprot[1]}), 64'd0);
    check("async_rst_prdata", 64'(in_prdata[1]), 64'd0);
    check("async_rst_addr_data", {out_paddr[1], out_pwdata[1]}, 64'd0);
    in_psel[1] = 1'b0;
    in_penable[1] = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (6) @(negedge clock);
    check("no_resp_after_rst", 64'({in_pready[1], out_psel[1]}), 64'd0);
    xfer(1, 32'h1000_0200, 1'b0, 32'h0, 4'h0, 3'h0, 3, 32'h2468_ACE0, 1'b0);

    // Randomized transfers
    for (int n = 0; n < 40; n++) begin
      int g;
      g = int'($urandom_range(0, N - 1));
      xfer(g, $urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
           3'($urandom_range(0, 7)), int'($urandom_range(1, 8)), $urandom,
           1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
